// File: rtl/int_port_balancer.sv
`default_nettype none
// ============================================================================
// Module : int_port_balancer
// Steers renamed integer uops to ALU issue ports: least-loaded selection with
// INT_PORT_LOAD_BALANCE_EN defined, plain round-robin otherwise.
// Rev    : 1.0
// ============================================================================
module int_port_balancer #(
  parameter  int NUM_UOPS  = 4,
  parameter  int NUM_PORTS = 4,
  parameter  int IQ_SIZE   = 8,
  localparam int CNT_W     = $clog2(IQ_SIZE + 1),
  localparam int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_UOPS-1:0]           IN_valid,
  input  logic [NUM_UOPS-1:0]           IN_isInt,
  input  logic [NUM_UOPS-1:0]           IN_stall,
  input  logic [NUM_PORTS-1:0]          IN_deq,
  input  logic                          IN_flush,
  output logic [NUM_UOPS*PORT_W-1:0]    OUT_order,
  output logic [NUM_PORTS*CNT_W-1:0]    OUT_portCnt
);

  localparam int c_acc_w = $clog2(NUM_UOPS + 1);
  // Wide enough for a saturated counter plus every slot of one cycle.
  localparam int c_sum_w = $clog2(IQ_SIZE + NUM_UOPS + 1);
  localparam logic [c_sum_w-1:0] c_sum_max = c_sum_w'(IQ_SIZE);

  logic [CNT_W-1:0]   r_cnt [NUM_PORTS];
  logic [PORT_W-1:0]  r_rr;

  logic [NUM_UOPS-1:0] w_int;
  logic [NUM_UOPS-1:0] w_accept;
  logic [PORT_W-1:0]   w_order [NUM_UOPS];
  logic [c_acc_w-1:0]  w_acc [NUM_PORTS];
  logic [c_acc_w-1:0]  w_acc_total;
  logic [c_sum_w-1:0]  w_sum [NUM_PORTS];
  logic [CNT_W-1:0]    w_cnt_nxt [NUM_PORTS];

  assign w_int    = IN_valid & IN_isInt;
  assign w_accept = w_int & ~IN_stall;

`ifdef INT_PORT_LOAD_BALANCE_EN
  logic [c_sum_w-1:0] w_load [NUM_PORTS];
  logic [PORT_W-1:0]  w_best;
  logic [PORT_W-1:0]  w_idx;

  // Strict less-than keeps the first candidate in scan order from r_rr on ties.
  always_comb begin : p_assign
    w_best = '0;
    w_idx  = '0;
    for (int p = 0; p < NUM_PORTS; p++) w_load[p] = c_sum_w'(r_cnt[p]);
    for (int s = 0; s < NUM_UOPS; s++) begin
      w_order[s] = '0;
      if (w_int[s]) begin
        w_best = r_rr;
        for (int j = 1; j < NUM_PORTS; j++) begin
          w_idx = r_rr + PORT_W'(j);
          if (w_load[w_idx] < w_load[w_best]) w_best = w_idx;
        end
        w_order[s]     = w_best;
        w_load[w_best] = w_load[w_best] + c_sum_w'(1);
      end
    end
  end
`else
  logic [PORT_W-1:0] w_k;

  always_comb begin : p_assign
    w_k = '0;
    for (int s = 0; s < NUM_UOPS; s++) begin
      w_order[s] = '0;
      if (w_int[s]) begin
        w_order[s] = r_rr + w_k;
        w_k        = w_k + PORT_W'(1);
      end
    end
  end
`endif

  always_comb begin : p_accept
    w_acc_total = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_acc[p] = '0;
      for (int s = 0; s < NUM_UOPS; s++) begin
        if (w_accept[s] && (w_order[s] == PORT_W'(p))) w_acc[p] = w_acc[p] + c_acc_w'(1);
      end
    end
    for (int s = 0; s < NUM_UOPS; s++) begin
      if (w_accept[s]) w_acc_total = w_acc_total + c_acc_w'(1);
    end
  end

  // Dequeue is applied before clamping so a full port that accepts and issues holds at IQ_SIZE.
  always_comb begin : p_cnt_next
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_sum[p] = c_sum_w'(r_cnt[p]) + c_sum_w'(w_acc[p]);
      if (IN_deq[p] && (w_sum[p] != '0)) w_sum[p] = w_sum[p] - c_sum_w'(1);
      w_cnt_nxt[p] = (w_sum[p] > c_sum_max) ? CNT_W'(IQ_SIZE) : w_sum[p][CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin : p_state
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) r_cnt[p] <= '0;
      r_rr <= '0;
    end else if (IN_flush) begin
      for (int p = 0; p < NUM_PORTS; p++) r_cnt[p] <= '0;
      r_rr <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) r_cnt[p] <= w_cnt_nxt[p];
      r_rr <= r_rr + PORT_W'(w_acc_total);
    end
  end

  always_comb begin : p_outputs
    OUT_order   = '0;
    OUT_portCnt = '0;
    for (int s = 0; s < NUM_UOPS; s++) OUT_order[s*PORT_W +: PORT_W] = w_order[s];
    for (int p = 0; p < NUM_PORTS; p++) OUT_portCnt[p*CNT_W +: CNT_W] = r_cnt[p];
  end

endmodule
`default_nettype wire

// File: tb/tb_int_port_balancer.sv
`default_nettype none
// ============================================================================
// Module : tb_int_port_balancer
// Directed and random checks of int_port_balancer against a queue-level model.
// Rev    : 1.0
// ============================================================================
module tb_int_port_balancer;

  localparam int NP = 4;
  localparam int NU = 4;
  localparam int IQ = 8;
  localparam int PW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  valid = '0;
  logic [3:0]  is_int = '0;
  logic [3:0]  stall = '0;
  logic [3:0]  deq = '0;
  logic        flush = 1'b0;
  logic [7:0]  order;
  logic [15:0] port_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int m_cnt [NP];
  int m_rr;

  int_port_balancer dut (
    .clk        (clk),
    .rst        (rst),
    .IN_valid   (valid),
    .IN_isInt   (is_int),
    .IN_stall   (stall),
    .IN_deq     (deq),
    .IN_flush   (flush),
    .OUT_order  (order),
    .OUT_portCnt(port_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int p = 0; p < NP; p++) m_cnt[p] = 0;
    m_rr = 0;
  endfunction

  // Each int slot goes to the lightest port; equal loads resolved by distance from m_rr.
  function automatic logic [7:0] model_order(input logic [3:0] v, input logic [3:0] ii);
    int load [NP];
    int k;
    int mn;
    int pick;
    logic [7:0] r;
    r = '0;
    k = 0;
    for (int p = 0; p < NP; p++) load[p] = m_cnt[p];
    for (int s = 0; s < NU; s++) begin
      if (v[s] && ii[s]) begin
`ifdef INT_PORT_LOAD_BALANCE_EN
        mn = load[0];
        for (int p = 1; p < NP; p++) if (load[p] < mn) mn = load[p];
        pick = -1;
        for (int d = 0; d < NP; d++)
          if (pick < 0 && load[(m_rr + d) % NP] == mn) pick = (m_rr + d) % NP;
`else
        mn   = 0;
        pick = (m_rr + k) % NP;
`endif
        load[pick]++;
        k++;
        r[s*PW +: PW] = 2'(pick);
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] model_cnt_vec();
    logic [15:0] r;
    for (int p = 0; p < NP; p++) r[p*4 +: 4] = 4'(m_cnt[p]);
    return r;
  endfunction

  function automatic void model_commit(input logic [7:0] eo, input logic [3:0] acc_m,
                                       input logic [3:0] dq, input logic fl);
    int acc [NP];
    int tot;
    int c;
    tot = 0;
    for (int p = 0; p < NP; p++) acc[p] = 0;
    for (int s = 0; s < NU; s++) begin
      if (acc_m[s]) begin
        acc[int'(eo[s*PW +: PW])]++;
        tot++;
      end
    end
    if (fl) begin
      model_reset();
    end else begin
      for (int p = 0; p < NP; p++) begin
        c = m_cnt[p] + acc[p] - int'(dq[p]);
        if (c < 0) c = 0;
        if (c > IQ) c = IQ;
        m_cnt[p] = c;
      end
      m_rr = (m_rr + tot) % NP;
    end
  endfunction

  task automatic step(input logic [3:0] v, input logic [3:0] ii, input logic [3:0] st,
                      input logic [3:0] dq, input logic fl, input string tag);
    logic [7:0] eo;
    @(negedge clk);
    valid = v; is_int = ii; stall = st; deq = dq; flush = fl;
    #1;
    eo = model_order(v, ii);
    chk({tag, ".order"}, 32'(order), 32'(eo));
    chk({tag, ".cnt"}, 32'(port_cnt), 32'(model_cnt_vec()));
    @(posedge clk);
    model_commit(eo, v & ii & ~st, dq, fl);
  endtask

  // Look at the order for a slot pattern with every slot stalled, so state is untouched.
  task automatic peek(input string tag, input logic [3:0] v, input logic [3:0] ii,
                      input logic [15:0] exp_cnt, input logic [7:0] exp_order);
    @(negedge clk);
    valid = v; is_int = ii; stall = 4'hF; deq = '0; flush = 1'b0;
    #1;
    chk({tag, ".cnt"}, 32'(port_cnt), 32'(exp_cnt));
    chk({tag, ".order"}, 32'(order), 32'(exp_order));
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset.cnt", 32'(port_cnt), 32'h0);
    valid = 4'hF; is_int = 4'hF;
    #1;
    chk("reset.order", 32'(order), 32'hE4);
    valid = '0; is_int = '0;
    @(negedge clk);
    rst = 1'b0;

    step(4'hF, 4'hF, 4'h0, 4'h0, 1'b0, "t1");
    peek("t1.after", 4'hF, 4'hF, 16'h1111, 8'hE4);

    step(4'h0, 4'h0, 4'h0, 4'h0, 1'b1, "flush0");
    step(4'h0, 4'h0, 4'h0, 4'hF, 1'b0, "deq_at_zero");
    peek("deq_at_zero.after", 4'h0, 4'h0, 16'h0000, 8'h00);

    step(4'b0011, 4'b0011, 4'h0, 4'h0, 1'b0, "t6.setup");
`ifdef INT_PORT_LOAD_BALANCE_EN
    peek("t6.peek", 4'hF, 4'b1101, 16'h0011, 8'hB2);
`else
    peek("t6.peek", 4'hF, 4'b1101, 16'h0011, 8'h32);
`endif
    step(4'hF, 4'b1101, 4'h0, 4'h0, 1'b0, "t6");
    step(4'h0, 4'h0, 4'h0, 4'h0, 1'b1, "flush1");

    repeat (10) step(4'hF, 4'hF, 4'h0, 4'h0, 1'b0, "sat");
    peek("sat.after", 4'hF, 4'hF, 16'h8888, 8'hE4);
    step(4'hF, 4'hF, 4'h0, 4'hF, 1'b0, "sat.deqacc");
    peek("sat.deqacc.after", 4'hF, 4'hF, 16'h8888, 8'hE4);
    step(4'hF, 4'hF, 4'h0, 4'h1, 1'b1, "flush2");
    peek("flush2.after", 4'hF, 4'hF, 16'h0000, 8'hE4);

    for (int i = 0; i < 400; i++) begin
      step(4'($urandom), 4'($urandom | $urandom), 4'($urandom & $urandom),
           4'($urandom & $urandom & $urandom), ($urandom_range(0, 39) == 0), "rnd");
    end

    repeat (3) step(4'hF, 4'hF, 4'h0, 4'h0, 1'b0, "burst");
    @(negedge clk);
    valid = 4'hF; is_int = 4'hF; stall = '0; deq = '0; flush = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst.cnt", 32'(port_cnt), 32'h0);
    chk("arst.order", 32'(order), 32'hE4);
    model_reset();
    valid = '0; is_int = '0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 100; i++) begin
      step(4'($urandom), 4'($urandom | $urandom), 4'($urandom & $urandom),
           4'($urandom & $urandom), 1'b0, "rnd2");
    end
    step(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, "final");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
